// File: rtl/turbo_pkg.sv
// Shared constants, FSM state encoding and RSC helpers for the parallel RSC checker.
package turbo_pkg;

  localparam int unsigned BW       = 8;
  localparam int unsigned K_SMALL  = 1056;
  localparam int unsigned K_LARGE  = 6144;
  localparam int unsigned NB_SMALL = K_SMALL / BW;   // 132 bytes
  localparam int unsigned NB_LARGE = K_LARGE / BW;   // 768 bytes
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned ERR_W    = 13;
  localparam int unsigned ST_W     = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_e;

  // One RSC step: returns {z, s_next}; s[0] is the newest state bit.
  function automatic logic [3:0] rsc_step(input logic c, input logic [2:0] s);
    logic a;
    logic z;
    a = c ^ s[1] ^ s[2];
    z = a ^ s[0] ^ s[2];
    return {z, s[1], s[0], a};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // Error counter add that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [3:0] b);
    logic [ERR_W:0] sum;
    sum = {1'b0, a} + (ERR_W+1)'(b);
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/rsc_reencode8.sv
// Combinational 8-step unroll of the RSC encoder, bit0 processed first.
module rsc_reencode8
  import turbo_pkg::*;
(
  input  logic [BW-1:0] c,
  input  logic [2:0]    s,
  output logic [BW-1:0] z,
  output logic [2:0]    s_out
);

  logic [2:0] st;
  logic [3:0] r;

  // Chain the single-bit steps, collecting the parity bit of each.
  always_comb begin
    st = s;
    r  = '0;
    z  = '0;
    for (int i = 0; i < int'(BW); i++) begin
      r    = rsc_step(c[i], st);
      z[i] = r[3];
      st   = r[2:0];
    end
    s_out = st;
  end

endmodule

// File: rtl/rsc_parallel_checker.sv
// Receive-side RSC parity/tail checker, one byte per cycle.
// Optional build macro ERR_POS_EN: records the byte index of the first parity mismatch.
module rsc_parallel_checker
  import turbo_pkg::*;
(
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             K,
  input  logic             in_valid,
  input  logic [BW-1:0]    xk,
  input  logic [BW-1:0]    zk,
  input  logic             tail_valid,
  input  logic [2:0]       tail_x,
  input  logic [2:0]       tail_z,
  output logic [BW-1:0]    ck_out,
  output logic             ck_valid,
  output logic             busy,
  output logic             done,
  output logic             block_ok,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err
);

  state_e             state_q, state_d;
  logic [2:0]         s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               k_q, k_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [BW-1:0]      ck_out_q, ck_out_d;
  logic               ck_valid_q, ck_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ok_q, ok_d;

  logic [BW-1:0]      enc_z;
  logic [2:0]         enc_s;
  logic [CNT_W-1:0]   last_idx;
  logic [2:0]         tail_st;
  logic [3:0]         tail_r;
  logic [3:0]         tail_mis;

`ifdef ERR_POS_EN
  logic [CNT_W-1:0]   fe_q, fe_d;
`endif

  rsc_reencode8 u_enc (
    .c     (xk),
    .s     (s_q),
    .z     (enc_z),
    .s_out (enc_s)
  );

  assign last_idx = k_q ? CNT_W'(NB_LARGE - 1) : CNT_W'(NB_SMALL - 1);

  // Tail termination: input forced to cancel feedback, expected x/z derived per step.
  always_comb begin
    tail_st  = s_q;
    tail_r   = '0;
    tail_mis = '0;
    for (int i = 0; i < 3; i++) begin
      tail_r   = rsc_step(tail_st[1] ^ tail_st[2], tail_st);
      tail_mis = tail_mis + 4'(tail_x[i] ^ tail_st[1] ^ tail_st[2]) + 4'(tail_z[i] ^ tail_r[3]);
      tail_st  = tail_r[2:0];
    end
  end

  // Next-state and output decode; start overrides everything, including a same-cycle byte.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    err_d      = err_q;
    ck_out_d   = ck_out_q;
    ck_valid_d = 1'b0;
`ifdef ERR_POS_EN
    fe_d       = fe_q;
`endif
    if (start) begin
      state_d = DATA;
      s_d     = '0;
      cnt_d   = '0;
      err_d   = '0;
      k_d     = K;
`ifdef ERR_POS_EN
      fe_d    = {CNT_W{1'b1}};
`endif
    end else begin
      case (state_q)
        DATA: begin
          if (in_valid) begin
            ck_valid_d = 1'b1;
            ck_out_d   = xk;
            s_d        = enc_s;
            err_d      = sat_add(err_q, popcount8(zk ^ enc_z));
            cnt_d      = cnt_q + CNT_W'(1);
`ifdef ERR_POS_EN
            // All-ones never matches a real byte index, so it doubles as "nothing captured".
            if ((fe_q == {CNT_W{1'b1}}) && (zk != enc_z)) fe_d = cnt_q;
`endif
            if (cnt_q == last_idx) state_d = TAIL;
          end
        end
        TAIL: begin
          if (tail_valid) begin
            err_d   = sat_add(err_q, tail_mis);
            s_d     = tail_st;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    ok_d   = (state_d == DONE) && (err_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      cnt_q      <= '0;
      k_q        <= 1'b0;
      err_q      <= '0;
      ck_out_q   <= '0;
      ck_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      err_q      <= err_d;
      ck_out_q   <= ck_out_d;
      ck_valid_q <= ck_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
    end
  end

`ifdef ERR_POS_EN
  // First-mismatch position register.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) fe_q <= '0;
    else         fe_q <= fe_d;
  end
  assign first_err = fe_q;
`else
  assign first_err = '0;
`endif

  assign ck_out   = ck_out_q;
  assign ck_valid = ck_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign block_ok = ok_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_rsc_parallel_checker.sv
// Directed bench for rsc_parallel_checker: table of whole-block scenarios plus abort/reset sequences.
module tb_rsc_parallel_checker;

  logic        clk = 1'b0;
  logic        aclr_n, start, K, in_valid, tail_valid;
  logic [7:0]  xk, zk;
  logic [2:0]  tail_x, tail_z;
  logic [7:0]  ck_out;
  logic        ck_valid, busy, done, block_ok;
  logic [12:0] err_cnt;
  logic [9:0]  first_err;

  always #5 clk = ~clk;

  rsc_parallel_checker dut (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .start      (start),
    .K          (K),
    .in_valid   (in_valid),
    .xk         (xk),
    .zk         (zk),
    .tail_valid (tail_valid),
    .tail_x     (tail_x),
    .tail_z     (tail_z),
    .ck_out     (ck_out),
    .ck_valid   (ck_valid),
    .busy       (busy),
    .done       (done),
    .block_ok   (block_ok),
    .err_cnt    (err_cnt),
    .first_err  (first_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state
  logic [7:0]  ck_q[$];
  int          ck_cnt, ck_bad, busy_bad, done_total;
  bit          in_block;
  logic [12:0] done_err;
  logic        done_ok;
  logic [9:0]  done_fe;

  // Reference encoder state
  logic [2:0]  ms;

  typedef struct {
    logic       k;
    int         mode;     // 0: all-zero data, 1: random, 2: first byte 01/4F then random
    int         gap;      // max idle cycles before each byte
    int         midx;     // byte index whose parity gets corrupted (-1 none)
    logic [7:0] mask;
    logic [2:0] tmx;
    logic [2:0] tmz;
    int         exp_err;
    logic       exp_ok;
    logic [9:0] exp_fe;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (ck_valid) begin
      ck_cnt++;
      if (ck_q.size() == 0) ck_bad++;
      else begin
        e = ck_q.pop_front();
        if (e !== ck_out) ck_bad++;
      end
    end
    if (in_block && !busy) busy_bad++;
    if (done) begin
      done_total++;
      done_err = err_cnt;
      done_ok  = block_ok;
      done_fe  = first_err;
      in_block = 1'b0;
    end
  endtask

  task automatic enc_byte(input logic [7:0] x, output logic [7:0] z);
    logic a;
    z = '0;
    for (int i = 0; i < 8; i++) begin
      a    = x[i] ^ ms[1] ^ ms[2];
      z[i] = a ^ ms[0] ^ ms[2];
      ms   = {ms[1], ms[0], a};
    end
  endtask

  // Start pulse, with a junk byte presented in the same cycle that must be discarded.
  task automatic send_start(input logic k);
    start = 1'b1; K = k; in_valid = 1'b1; xk = 8'hA5; zk = 8'h5A; tail_valid = 1'b0;
    in_block = 1'b1;
    step();
    start = 1'b0; K = 1'b0; in_valid = 1'b0;
    ms = 3'b000;
  endtask

  task automatic send_bytes(input int n, input int mode, input int gap, input int midx,
                            input logic [7:0] mask);
    logic [7:0] x, z;
    int g;
    for (int i = 0; i < n; i++) begin
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0; tail_valid = 1'b1; tail_x = 3'b111; tail_z = 3'b101;
        step();
      end
      tail_valid = 1'b0;
      if (mode == 0)                x = 8'h00;
      else if (mode == 2 && i == 0) x = 8'h01;
      else                          x = 8'($urandom);
      enc_byte(x, z);
      if (mode == 2 && i == 0) z = 8'h4F;
      if (i == midx) z = z ^ mask;
      in_valid = 1'b1; xk = x; zk = z;
      ck_q.push_back(x);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_tail(input logic [2:0] mx, input logic [2:0] mz);
    logic [2:0] tx, tz;
    // A byte arriving during TAIL must be ignored.
    in_valid = 1'b1; xk = 8'hFF; zk = 8'h00;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx[i] = ms[1] ^ ms[2];
      tz[i] = ms[0] ^ ms[2];
      ms    = {ms[1], ms[0], 1'b0};
    end
    tail_valid = 1'b1; tail_x = tx ^ mx; tail_z = tz ^ mz;
    step();
    tail_valid = 1'b0;
    step();
    step();
  endtask

  task automatic clear_mon();
    ck_q.delete();
    ck_cnt = 0; ck_bad = 0; busy_bad = 0;
  endtask

  initial begin
    int d0, nb;
    vecs[0] = '{1'b0, 0, 0, -1, 8'h00, 3'b000, 3'b000, 0,  1'b1, 10'h3FF};
    vecs[1] = '{1'b0, 2, 0, -1, 8'h00, 3'b000, 3'b000, 0,  1'b1, 10'h3FF};
    vecs[2] = '{1'b0, 2, 0,  0, 8'h01, 3'b000, 3'b000, 1,  1'b0, 10'd0};
    vecs[3] = '{1'b1, 1, 5, -1, 8'h00, 3'b000, 3'b000, 0,  1'b1, 10'h3FF};
    vecs[4] = '{1'b0, 1, 0, -1, 8'h00, 3'b000, 3'b100, 1,  1'b0, 10'h3FF};
    vecs[5] = '{1'b0, 1, 2, 131, 8'hFF, 3'b011, 3'b000, 10, 1'b0, 10'd131};
    vecs[6] = '{1'b1, 1, 1, 767, 8'h81, 3'b000, 3'b000, 2,  1'b0, 10'd767};

    aclr_n = 1'b0; start = 1'b0; K = 1'b0; in_valid = 1'b0; tail_valid = 1'b0;
    xk = '0; zk = '0; tail_x = '0; tail_z = '0;
    in_block = 1'b0; done_total = 0; ms = '0;
    done_err = '0; done_ok = 1'b0; done_fe = '0;
    clear_mon();

    #1;
    check("reset_data_outs", {14'd0, ck_out, ck_valid, busy, done, block_ok, first_err}, 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    step(); step();
    aclr_n = 1'b1;
    step();

    // Table-driven whole-block scenarios
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      d0 = done_total;
      nb = vecs[v].k ? 768 : 132;
      send_start(vecs[v].k);
      send_bytes(nb, vecs[v].mode, vecs[v].gap, vecs[v].midx, vecs[v].mask);
      send_tail(vecs[v].tmx, vecs[v].tmz);
      check($sformatf("v%0d_done_count", v), 32'(done_total - d0), 32'd1);
      check($sformatf("v%0d_err_cnt", v), 32'(done_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_block_ok", v), 32'(done_ok), 32'(vecs[v].exp_ok));
`ifdef ERR_POS_EN
      check($sformatf("v%0d_first_err", v), 32'(done_fe), 32'(vecs[v].exp_fe));
`else
      check($sformatf("v%0d_first_err", v), 32'(done_fe), 32'd0);
`endif
      check($sformatf("v%0d_ck_valid_count", v), 32'(ck_cnt), 32'(nb));
      check($sformatf("v%0d_ck_out_errors", v), 32'(ck_bad), 32'd0);
      check($sformatf("v%0d_busy_drop", v), 32'(busy_bad), 32'd0);
      check($sformatf("v%0d_err_cnt_held", v), 32'(err_cnt), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_idle_after", v), {30'd0, busy, done}, 32'd0);
    end

    // Abort a K=1 block at byte 50, then a clean K=0 block
    clear_mon();
    d0 = done_total;
    send_start(1'b1);
    send_bytes(50, 1, 0, 10, 8'hFF);
    check("abort_ck_count", 32'(ck_cnt), 32'd50);
    check("abort_err_partial", 32'(err_cnt), 32'd8);
    ck_cnt = 0;
    send_start(1'b0);
    check("abort_err_cleared", 32'(err_cnt), 32'd0);
    send_bytes(132, 1, 1, -1, 8'h00);
    send_tail(3'b000, 3'b000);
    check("abort_done_count", 32'(done_total - d0), 32'd1);
    check("abort_err_cnt", 32'(done_err), 32'd0);
    check("abort_block_ok", 32'(done_ok), 32'd1);
    check("abort_ck_count2", 32'(ck_cnt), 32'd132);
    check("abort_ck_out_errors", 32'(ck_bad), 32'd0);
    check("abort_busy_drop", 32'(busy_bad), 32'd0);

    // Asynchronous reset at byte 10, then a clean block
    clear_mon();
    d0 = done_total;
    send_start(1'b0);
    send_bytes(10, 1, 0, 3, 8'h0F);
    in_block = 1'b0;
    #2 aclr_n = 1'b0;
    #1;
    check("aclr_data_outs", {14'd0, ck_out, ck_valid, busy, done, block_ok, first_err}, 32'd0);
    check("aclr_err_cnt", 32'(err_cnt), 32'd0);
    step();
    aclr_n = 1'b1;
    step();
    check("aclr_no_done", 32'(done_total - d0), 32'd0);
    clear_mon();
    d0 = done_total;
    send_start(1'b0);
    send_bytes(132, 1, 0, -1, 8'h00);
    send_tail(3'b000, 3'b000);
    check("post_aclr_done_count", 32'(done_total - d0), 32'd1);
    check("post_aclr_err_cnt", 32'(done_err), 32'd0);
    check("post_aclr_block_ok", 32'(done_ok), 32'd1);
    check("post_aclr_ck_count", 32'(ck_cnt), 32'd132);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
